// File: rtl/tff_load_sequencer.sv
// Loads a target word into a bank of T flip-flops through a single shared toggle driver,
// scanning LSB-first and toggling only the bits that differ from the target.
module tff_load_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [WIDTH-1:0]           load_data,
    input  logic                       hold,
    output logic [WIDTH-1:0]           q,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(WIDTH+1)-1:0] toggle_count
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] tog_en;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    run_cnt_q, run_cnt_d;
    logic [CW-1:0]    toggle_count_q, toggle_count_d;
    logic             bit_diff;
    logic             last_bit;

    assign bit_diff = target_q[idx_q] ^ q_q[idx_q];
    assign last_bit = (idx_q == IW'(WIDTH - 1));

    always_comb begin
        state_d        = state_q;
        target_d       = target_q;
        idx_d          = idx_q;
        run_cnt_d      = run_cnt_q;
        toggle_count_d = toggle_count_q;
        tog_en         = '0;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    target_d  = load_data;
                    idx_d     = '0;
                    run_cnt_d = '0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (!hold) begin
                    if (bit_diff) begin
                        tog_en[idx_q] = 1'b1;
                        run_cnt_d     = run_cnt_q + CW'(1);
                    end
                    // The final count includes the toggle made on the last bit.
                    if (last_bit) begin
                        state_d        = DONE;
                        toggle_count_d = run_cnt_d;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Each bank bit only ever inverts under its own enable; never loaded directly.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bank
        assign q_d[gi] = q_q[gi] ^ tog_en[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            target_q       <= '0;
            idx_q          <= '0;
            run_cnt_q      <= '0;
            toggle_count_q <= '0;
            q_q            <= '0;
        end else begin
            state_q        <= state_d;
            target_q       <= target_d;
            idx_q          <= idx_d;
            run_cnt_q      <= run_cnt_d;
            toggle_count_q <= toggle_count_d;
            q_q            <= q_d;
        end
    end

    assign load_ready   = (state_q == IDLE);
    assign busy         = (state_q == SCAN);
    assign done         = (state_q == DONE);
    assign q            = q_q;
    assign toggle_count = toggle_count_q;

endmodule

// File: tb/tb_tff_load_sequencer.sv
// Self-checking bench for tff_load_sequencer: table-driven loads, hand-written reset/hold
// corner cases, and randomized loads checked against a bit-scan reference model.
module tb_tff_load_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_valid = 1'b0;
    logic         load_ready;
    logic [W-1:0] load_data = '0;
    logic         hold = 1'b0;
    logic [W-1:0] q;
    logic         busy;
    logic         done;
    logic [3:0]   toggle_count;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] mq = '0;

    typedef struct {
        logic [W-1:0] data;
        int           cnt;
        int           hold_at;
        int           hold_len;
    } vec_t;

    vec_t tbl [6];

    tff_load_sequencer #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .hold         (hold),
        .q            (q),
        .busy         (busy),
        .done         (done),
        .toggle_count (toggle_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // After k bits resolved, the low k bits match the target and the rest are unchanged.
    function automatic logic [W-1:0] model(input logic [W-1:0] old, input logic [W-1:0] tgt, input int k);
        logic [W-1:0] m;
        m = (k >= W) ? '1 : W'((16'd1 << k) - 16'd1);
        return (old & ~m) | (tgt & m);
    endfunction

    task automatic do_load(input logic [W-1:0] data, input int exp_cnt,
                           input int hold_at, input int hold_len, input bit rnd);
        logic [W-1:0] old;
        int k, e, holds;
        bit h;
        old = mq; k = 0; e = 0; holds = 0;
        load_valid = 1'b1;
        load_data  = data;
        hold       = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        step();
        chk("accept_busy", busy, 1);
        chk("accept_ready", load_ready, 0);
        while (k < W && e < 4 * W) begin
            e++;
            h = (e > hold_at && e <= hold_at + hold_len) || (rnd && $urandom_range(0, 3) == 0);
            hold       = h;
            load_valid = rnd ? 1'($urandom_range(0, 1)) : 1'(e & 1);
            load_data  = rnd ? W'($urandom) : '0;
            step();
            if (h) holds++;
            else   k++;
            chk("scan_q", q, model(old, data, k));
            if (k < W) begin
                chk("scan_busy", busy, 1);
                chk("scan_done", done, 0);
                chk("scan_ready", load_ready, 0);
            end
        end
        if (k < W) chk("scan_timeout", k, W);
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_cnt", toggle_count, exp_cnt);
        chk("done_ready", load_ready, 0);
        hold       = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        load_valid = 1'b0;
        step();
        chk("post_done", done, 0);
        chk("post_ready", load_ready, 1);
        chk("post_q", q, data);
        chk("post_cnt", toggle_count, exp_cnt);
        mq = data;
        $display("load %02h from %02h: holds=%0d toggles=%0d q=%02h", data, old, holds, toggle_count, q);
    endtask

    initial begin
        tbl[0] = '{data: 8'hA5, cnt: 4, hold_at: 0, hold_len: 0};
        tbl[1] = '{data: 8'hA5, cnt: 0, hold_at: 0, hold_len: 0};
        tbl[2] = '{data: 8'h5A, cnt: 8, hold_at: 0, hold_len: 0};
        tbl[3] = '{data: 8'hC3, cnt: 4, hold_at: 3, hold_len: 3};
        tbl[4] = '{data: 8'hFF, cnt: 4, hold_at: 0, hold_len: 0};
        tbl[5] = '{data: 8'h00, cnt: 8, hold_at: 0, hold_len: 0};

        // Reset held for two cycles while a load is offered.
        rst = 1'b1; load_valid = 1'b1; load_data = 8'hFF;
        step();
        step();
        chk("rst_q", q, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", toggle_count, 0);
        chk("rst_ready", load_ready, 1);
        rst = 1'b0; load_valid = 1'b0;
        step();
        chk("rst_noload_busy", busy, 0);
        chk("rst_noload_q", q, 0);
        $display("reset: q=%02h busy=%0b ready=%0b", q, busy, load_ready);

        for (int i = 0; i < 6; i++)
            do_load(tbl[i].data, tbl[i].cnt, tbl[i].hold_at, tbl[i].hold_len, 1'b0);

        // Reset at E4 of a scan aborts the load.
        load_valid = 1'b1; load_data = 8'hA5;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1;
        step();
        chk("abort_q", q, 0);
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", load_ready, 1);
        chk("abort_cnt", toggle_count, 0);
        rst = 1'b0;
        step();
        chk("abort_after_done", done, 0);
        chk("abort_after_busy", busy, 0);
        mq = '0;
        $display("abort: q=%02h done=%0b cnt=%0d", q, done, toggle_count);

        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] d;
            d = W'($urandom);
            do_load(d, $countones(mq ^ d), 0, 0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tff_load_sequencer.md
# tff_load_sequencer

Load controller for a bank of T flip-flops that presents D-register behaviour through a shared, one-toggle-per-cycle driver. A target word is accepted over a valid/ready handshake. The block then walks the bank LSB-first and toggles only the bits whose stored value differs from the target. It reports completion with a one-cycle `done` pulse and the number of toggles spent. It sits where a bank of T-to-D converted flip-flops needs to be loaded under a single-toggle-driver constraint.

## Interface
- `WIDTH`, default 8: number of T flip-flops in the bank (≥2).
- `clk` input 1: single clock, rising-edge.
- `rst` input 1: reset, synchronous and active-high.
- `load_valid` input 1: requester has a target word on `load_data`.
- `load_ready` output 1: block can accept a load (high only in IDLE).
- `load_data` input WIDTH: target word, sampled on the accepting edge only.
- `hold` input 1: stall request; freezes the scan while high.
- `q` output WIDTH: current state of the T flip-flop bank (registered).
- `busy` output 1: high while scanning.
- `done` output 1: one-cycle pulse when a load completes.
- `toggle_count` output $clog2(WIDTH+1): toggles performed by the last completed load.

## Operation
- Internal bank: `q[i]` inverts on a clock edge only when its toggle enable is high.
  - At most one enable is high per cycle (shared driver).
  - `q` is never written directly, except by reset.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - `load_ready`=1, `busy`=0, `done`=0.
  - On `load_valid && load_ready` at an edge: capture `load_data` into `target`, set bit index `idx`=0, clear the running counter, go to SCAN.
- SCAN:
  - `busy`=1, `load_ready`=0.
  - Each edge with `hold`=0: if `target[idx] != q[idx]`, toggle `q[idx]` and increment the running counter; then `idx`++.
  - After bit WIDTH-1 is processed, go to DONE.
  - Each edge with `hold`=1: no toggle, `idx` and the counter unchanged.
- DONE:
  - `done`=1 and `busy`=0 for exactly one cycle.
  - `toggle_count` already holds the final running count.
  - Return to IDLE on the next edge; `hold` is ignored.
- `toggle_count` is registered. It updates only on the SCAN→DONE edge and holds its value until the next completion.
- `load_valid` outside IDLE is ignored. No queueing; the requester must hold `load_valid` until `load_ready`.
- `hold` outside SCAN has no effect.
- Invariant: after `done`, `q` equals the captured `target`.
- Invariant: `toggle_count` equals the popcount of (`q` before load XOR `target`). Range is 0..WIDTH, with no overflow.

## Timing
- Reset values, after any edge with `rst`=1:
  - `q`=0, `busy`=0, `done`=0, `toggle_count`=0.
  - State IDLE, so `load_ready`=1.
  - `load_valid` is ignored while `rst`=1.
- Reset mid-SCAN or in DONE: the load is aborted, the target is discarded, and `q` is cleared to 0. No `done` pulse is issued for the aborted load.
- Accept edge E0: bit i is resolved at edge E(i+1), so `q[i]` shows its final value from E(i+1) onward.
- With no hold:
  - `busy` is high from E0 to E(WIDTH).
  - `done` is high from E(WIDTH) to E(WIDTH+1).
  - `load_ready` returns high at E(WIDTH+1).
- Each cycle with `hold`=1 in SCAN delays every later event by exactly one cycle.
- Throughput: one load per WIDTH+2 cycles when back-to-back. The next accept edge is earliest at E(WIDTH+2).

## Test plan
- Reset: `rst`=1 for 2 cycles with `load_valid`=1 and `load_data`=8'hFF -> `q`=0, `busy`=0, `done`=0, `toggle_count`=0, `load_ready`=1, no load accepted.
- Load 8'hA5 from `q`=0 -> `q` steps 01, 05, 25, A5 at E1, E3, E6, E8; `done` high for one cycle after E8; `toggle_count`=4.
- Reload 8'hA5 -> `q` is never altered; `done` at the same latency (WIDTH+1); `toggle_count`=0.
- Load 8'h5A from 8'hA5 -> one bit flips per cycle for 8 cycles; `q`=5A; `toggle_count`=8.
- `hold`=1 for 3 cycles after E3 while also pulsing `load_valid` with 8'h00 -> `done` arrives 3 cycles later than nominal; `q`=target; the 8'h00 request is not accepted (`load_ready`=0).
- `rst` asserted at E4 of a scan -> `q`=0 after that edge; no `done` pulse; `load_ready`=1; `toggle_count`=0.
